safe_softmax_log2_neg: RTL and testbench

SAFE_SOFTMAX_LOG2_NEG -- requirements
Module: safe_softmax_log2_neg

---
 rtl/safe_softmax_log2_neg.sv | 135 +++++++++++++
 tb/tb_safe_softmax_log2_neg.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/safe_softmax_log2_neg.sv
// safe_softmax_log2_neg: -log2(y) for an unsigned Q2.13 input y in 1..8192.
// Normalises y to a Q1.15 mantissa, then extracts 13 fraction bits of
// log2(mantissa) by repeated squaring (one bit per cycle). The result is
// returned as integer part + 0.13 fraction, in the same format as the
// softmax exp2 LUT input.
module safe_softmax_log2_neg #(
  parameter int D_W = 16
) (
  input  logic           I_CLK,
  input  logic           I_RST,
  input  logic           I_VALID,
  output logic           O_READY,
  input  logic [D_W-1:0] I_X,
  output logic           O_VALID,
  input  logic           I_READY,
  output logic [3:0]     O_INT,
  output logic [D_W-4:0] O_FRAC,
  output logic           O_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ITER, S_DONE} state_t;

  state_t         r_state;
  logic [D_W-1:0] r_x;
  logic [15:0]    r_m;
  logic [12:0]    r_l;
  logic [3:0]     r_k;
  logic [3:0]     r_cnt;
  logic [3:0]     r_int;
  logic [12:0]    r_frac;
  logic           r_err;
  logic           r_valid;

  logic [3:0]     w_p;
  logic [3:0]     w_k;
  logic [15:0]    w_mant;
  logic [16:0]    w_sq;
  logic [15:0]    w_m_next;
  logic [12:0]    w_l_next;

  // Leading-one position of the captured input (bits 0..13 cover 1..8192).
  always_comb begin
    w_p = '0;
    for (int i = 0; i < 14; i++)
      if (r_x[i]) w_p = 4'(i);
  end

  assign w_k    = 4'd13 - w_p;
  assign w_mant = 16'(r_x << (4'd15 - w_p));

  // Square of the Q1.15 mantissa, kept as P[31:15]; bit 16 is P[31].
  // Lower product bits are truncated.
  assign w_sq     = 17'(({16'd0, r_m} * {16'd0, r_m}) >> 15);
  assign w_m_next = w_sq[16] ? w_sq[16:1] : w_sq[15:0];
  assign w_l_next = {r_l[11:0], w_sq[16]};

  assign O_READY = (r_state == S_IDLE);
  assign O_VALID = r_valid;
  assign O_INT   = r_int;
  assign O_FRAC  = r_frac;
  assign O_ERR   = r_err;

  // Control FSM plus datapath registers; results only change on entry to DONE
  // so they stay stable while the consumer stalls.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_m     <= '0;
      r_l     <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_int   <= '0;
      r_frac  <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (I_VALID) begin
            r_x     <= I_X;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_x == '0) begin
            r_int   <= 4'd15;
            r_frac  <= '1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (r_x > D_W'(8192)) begin
            r_int   <= '0;
            r_frac  <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k     <= w_k;
            r_m     <= w_mant;
            r_l     <= '0;
            r_cnt   <= '0;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_m   <= w_m_next;
          r_l   <= w_l_next;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd12) begin
            // -log2(y) = k - L/8192; borrow one from k when L is non-zero.
            if (w_l_next == '0) begin
              r_int  <= r_k;
              r_frac <= '0;
            end else begin
              r_int  <= r_k - 4'd1;
              r_frac <= 13'd0 - w_l_next;
            end
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Valid is raised one cycle after the result registers load.
          if (!r_valid) begin
            r_valid <= 1'b1;
          end else if (I_READY) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_safe_softmax_log2_neg.sv
// Scoreboard bench for safe_softmax_log2_neg: driver pushes expected results,
// monitor pops and compares on every output handshake.
module tb_safe_softmax_log2_neg;

  logic        I_CLK = 1'b0;
  logic        I_RST;
  logic        I_VALID;
  logic        I_READY;
  logic [15:0] I_X;
  logic        O_READY;
  logic        O_VALID;
  logic [3:0]  O_INT;
  logic [12:0] O_FRAC;
  logic        O_ERR;

  safe_softmax_log2_neg #(.D_W(16)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_VALID(I_VALID), .O_READY(O_READY),
    .I_X(I_X), .O_VALID(O_VALID), .I_READY(I_READY), .O_INT(O_INT),
    .O_FRAC(O_FRAC), .O_ERR(O_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [15:0] x;
    logic [3:0]  ei;
    logic [12:0] ef;
    logic        ee;
    int          lat;
    int          acc;
    int          lut;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   rmode = 0;   // 0: ready high, 1: random, 2: ready low

  always @(posedge I_CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_near(input string name, input longint act, input longint req, input int tol);
    nvec++;
    if (act > req + tol || act < req - tol) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d +/-%0d (t=%0t)", name, act, req, tol, $time);
    end
  endtask

  // Reference: normalise to [1,2), then extract log2 fraction bits by
  // squaring with truncation to 15 fractional bits.
  function automatic exp_t model(input logic [15:0] x, input int lut);
    exp_t   e;
    longint m, p;
    int     k, l;
    e.x = x; e.lut = lut; e.acc = 0;
    if (x == 0) begin
      e.ei = 4'd15; e.ef = 13'd8191; e.ee = 1'b1; e.lat = 2;
    end else if (x > 8192) begin
      e.ei = 4'd0; e.ef = 13'd0; e.ee = 1'b1; e.lat = 2;
    end else begin
      m = x; k = 0;
      while (m < 8192) begin m = m * 2; k++; end
      m = m * 4;            // 8192 (1.0 in Q2.13) -> 32768 (1.0 in Q1.15)
      l = 0;
      for (int j = 0; j < 13; j++) begin
        p = m * m;
        if (p >= (longint'(1) << 31)) begin l = l * 2 + 1; m = p / 65536; end
        else begin l = l * 2; m = p / 32768; end
      end
      if (l == 0) begin e.ei = 4'(k); e.ef = 13'd0; end
      else begin e.ei = 4'(k - 1); e.ef = 13'(8192 - l); end
      e.ee = 1'b0; e.lat = 15;
    end
    return e;
  endfunction

  function automatic int lut_val(input int i);
    return $rtoi(8192.0 * (2.0 ** (-i / 32.0)) + 0.5);
  endfunction

  // Downstream ready generator.
  initial begin
    I_READY = 1'b1;
    forever begin
      @(posedge I_CLK); #1;
      case (rmode)
        0:       I_READY = 1'b1;
        1:       I_READY = 1'($urandom_range(0, 1));
        default: I_READY = 1'b0;
      endcase
    end
  end

  // Monitor: latency on valid rise, hold while stalled, compare on handshake.
  logic        pv = 1'b0, pr = 1'b0, he = 1'b0;
  logic [3:0]  hi = '0;
  logic [12:0] hf = '0;
  initial begin
    exp_t e;
    real  r;
    forever begin
      @(negedge I_CLK);
      if (I_RST) begin
        pv = 1'b0; pr = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("hold_valid", O_VALID, 1);
          chk("hold_int", O_INT, hi);
          chk("hold_frac", O_FRAC, hf);
          chk("hold_err", O_ERR, he);
          chk("hold_ready", O_READY, 0);
        end
        if (O_VALID && !pv) begin
          if (sb.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL spurious_valid: got O_VALID=1, expected no result pending (t=%0t)", $time);
          end else begin
            chk("latency", cyc - sb[0].acc, sb[0].lat);
          end
        end
        if (O_VALID && I_READY && sb.size() > 0) begin
          e = sb.pop_front();
          chk("int", O_INT, e.ei);
          chk("frac", O_FRAC, e.ef);
          chk("err", O_ERR, e.ee);
          if (!e.ee) begin
            r = -$ln(real'(e.x) / 8192.0) / $ln(2.0) * 8192.0;
            chk_near("approx", longint'(O_INT) * 8192 + O_FRAC, $rtoi(r + 0.5), 2);
          end
          if (e.lut >= 0) begin
            chk("lut_int", O_INT, 0);
            chk_near("lut_frac", O_FRAC, e.lut * 256, 3);
          end
        end
        pv = O_VALID; pr = I_READY; hi = O_INT; hf = O_FRAC; he = O_ERR;
      end
    end
  end

  // Wait for ready (toggling junk on the inputs meanwhile), then issue one op.
  task automatic send(input logic [15:0] x, input int lut);
    exp_t e;
    int   n = 0;
    while (!O_READY && n < 300) begin
      I_VALID = 1'($urandom_range(0, 1));
      I_X     = 16'($urandom);
      @(posedge I_CLK); #1;
      n++;
    end
    if (!O_READY) begin
      nvec++; nerr++;
      $display("FAIL ready_timeout: got O_READY=0, expected 1 within 300 cycles");
      I_VALID = 1'b0;
      return;
    end
    I_VALID = 1'b1;
    I_X     = x;
    @(posedge I_CLK); #1;
    e = model(x, lut);
    e.acc = cyc;
    sb.push_back(e);
    I_VALID = 1'b0;
    I_X     = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 2000) begin @(negedge I_CLK); n++; end
    if (sb.size() > 0) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge I_CLK); #1;
  endtask

  int dir [12] = '{8192, 4096, 1, 6144, 4186, 0, 9000, 65535, 8191, 2, 8193, 3};

  initial begin
    int   n;
    logic seen;
    logic [15:0] x;
    I_RST = 1'b1; I_VALID = 1'b0; I_X = '0;
    repeat (3) @(posedge I_CLK);
    @(negedge I_CLK);
    chk("rst_valid", O_VALID, 0);
    chk("rst_int", O_INT, 0);
    chk("rst_frac", O_FRAC, 0);
    chk("rst_err", O_ERR, 0);
    @(posedge I_CLK); #1;
    I_RST = 1'b0;
    @(negedge I_CLK);
    chk("rst_ready", O_READY, 1);
    @(posedge I_CLK); #1;

    foreach (dir[i]) send(dir[i][15:0], -1);
    for (int i = 0; i < 32; i++) send(16'(lut_val(i)), i);
    drain();

    // Stall in DONE for 5 cycles.
    rmode = 2;
    send(16'd6144, -1);
    n = 0;
    while (!O_VALID && n < 50) begin @(negedge I_CLK); n++; end
    chk("stall_valid_seen", O_VALID, 1);
    repeat (5) @(negedge I_CLK);
    rmode = 0;
    drain();

    // Abort mid-iteration: reset at ITER cycle 6.
    send(16'd8192, -1);
    repeat (7) @(posedge I_CLK);
    #1 I_RST = 1'b1;
    @(negedge I_CLK);
    @(negedge I_CLK);
    chk("abort_ready", O_READY, 1);
    chk("abort_valid", O_VALID, 0);
    chk("abort_int", O_INT, 0);
    @(posedge I_CLK); #1;
    I_RST = 1'b0;
    sb.delete();
    seen = 1'b0;
    repeat (25) begin @(negedge I_CLK); if (O_VALID) seen = 1'b1; end
    chk("abort_no_valid", seen, 0);
    @(posedge I_CLK); #1;

    // Randomized traffic with random downstream back-pressure.
    rmode = 1;
    repeat (60) begin
      if ($urandom_range(0, 9) == 0)
        x = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(8193, 65535));
      else
        x = 16'($urandom_range(1, 8192));
      send(x, -1);
    end
    drain();
    rmode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
